serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder, one bit per clock, LSB first. Carry chain is a
//  full adder built from two half_adder instances plus a carry flip-flop.
//  Sits downstream of half_adder and consumes its sum/carry outputs.
//  Presents a start/busy/done handshake to a controller or testbench.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; legal range >= 1
//  CNT_W  $clog2(WIDTH+1)  localparam; bit-counter width, not overridable
// PORTS
//  clk        input   1      single clock; all state updates on rising edge
//  rst        input   1      synchronous, active-high reset
//  start      input   1      request: sample a/b and begin; honoured only when idle
//  a          input   WIDTH  operand A, sampled on the accepted start edge
//  b          input   WIDTH  operand B, sampled on the accepted start edge
//  busy       output  1      high while bits are being processed
//  done       output  1      one-cycle pulse; sum/carry_out valid
//  sum        output  WIDTH  result (a+b) mod 2^WIDTH; held until next accepted start
//  carry_out  output  1      carry out of MSB; held with sum
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, sum=0, carry_out=0, carry ff=0, count=0.
//   rst has priority over start in the same cycle.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: start=1 -> load shift regs A<=a, B<=b; carry<=0; count<=0; go RUN.
//   RUN:  each cycle: bit = A[0]^B[0]^carry; carry <= majority(A[0],B[0],carry);
//         shift result bit into sum MSB (sum <= {bit, sum[WIDTH-1:1]});
//         A,B shift right; count++. When count == WIDTH-1 this cycle -> DONE.
//   DONE: done=1 for exactly this cycle, carry_out = final carry; then IDLE.
//         start=1 in DONE is accepted (back-to-back), next state RUN.
//  Latency: start high in cycle 0 -> busy=1 in cycles 1..WIDTH -> done=1 in
//   cycle WIDTH+1. Throughput: one addition per WIDTH+1 cycles.
//  start while busy: ignored; operands not resampled; no error flag.
//  sum is not valid during RUN (partially shifted); consumers sample on done.
//  carry_out updates only when entering DONE; holds otherwise.
//  Reset mid-RUN: operation aborted, all outputs return to reset values next
//   cycle; no done pulse is produced for the aborted operation.
//  WIDTH=1: single RUN cycle, done in cycle 2.
//  Arithmetic: {carry_out,sum} == a + b (WIDTH+1 bits), unsigned.
// STRUCTURE
//  serial_adder_defs.vh: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1,
//   ST_DONE=2'd2) as localparams; shared with future serial datapath blocks.
//  Sub-module full_adder (a, b, cin, sum, cout): two half_adder instances,
//   cout = c1 | c2. Purely combinational; the carry register lives in
//   serial_adder. One full_adder instance in serial_adder.
//  serial_adder holds FSM, counter, A/B/sum shift regs, carry ff.
// TESTING  (WIDTH=8 unless noted; cycle 0 = start asserted)
//  1. a=3, b=5, start 1 cycle -> busy 1..8, done=1 in cycle 9, sum=8, carry_out=0.
//  2. a=255, b=1 -> sum=0, carry_out=1 at done; a=200, b=100 -> sum=44, carry_out=1.
//  3. a=10,b=20 started; start pulsed again in cycle 4 with a=99,b=99 ->
//     ignored; done cycle 9 with sum=30, carry_out=0; exactly one done pulse.
//  4. rst asserted in cycle 5 of a run -> next cycle busy=0, done=0, sum=0,
//     carry_out=0; no done pulse follows; new start then completes normally.
//  5. Back-to-back: start held high continuously with a=1,b=2 then a=7,b=9
//     presented on done cycle -> done at 9 (sum=3) and 18 (sum=16).
//  6. WIDTH=1: a=1,b=1 -> done in cycle 2, sum=0, carry_out=1; plus random
//     regression (WIDTH=8, 1000 vectors) checking {carry_out,sum}==a+b.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//  Shared definitions for the bit-serial datapath blocks.
//  Exports:
//   state_t           FSM state encoding (IDLE/RUN/DONE)
//   SERIAL_WIDTH_DEF  default operand width
// ---------------------------------------------------------------------------
package serial_adder_pkg;

   localparam int SERIAL_WIDTH_DEF = 8;

   // Encodings are fixed so other serial blocks can decode a captured state.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
//  Start/busy/done handshake plus operand and result bus.
//  Ports (signals):
//   start      controller -> adder  request, honoured only when idle
//   a, b       controller -> adder  operands, sampled on accepted start
//   busy       adder -> controller  bits being processed
//   done       adder -> controller  one-cycle pulse, result valid
//   sum        adder -> controller  (a+b) mod 2^WIDTH
//   carry_out  adder -> controller  carry out of MSB
//  Modports: master (controller side), slave (adder side).
// ---------------------------------------------------------------------------
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;

   modport master (
      output start, a, b,
      input  busy, done, sum, carry_out
   );

   modport slave (
      input  start, a, b,
      output busy, done, sum, carry_out
   );
endinterface

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//  Combinational 1-bit full adder built from two half adders.
//  Ports: a, b, cin (in); sum, cout (out).
//  The two half-adder carries can never both be 1, so OR-ing them gives the
//  majority function.
// ---------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic s1, c1, c2;

   half_adder u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
   half_adder u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

   assign cout = c1 | c2;
endmodule

// File: rtl/half_adder.sv
// ---------------------------------------------------------------------------
// half_adder
//  Combinational 1-bit half adder.
//  Ports: a, b (in); sum = a^b, carry = a&b (out).
// ---------------------------------------------------------------------------
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b;
   assign carry = a & b;
endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//  Bit-serial WIDTH-bit unsigned adder, one bit per clock, LSB first.
//  Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (wins over start)
//   bus   serial_adder_if.slave: start/a/b in, busy/done/sum/carry_out out
//  Timing: start accepted in cycle 0 -> busy in cycles 1..WIDTH ->
//   done pulse in cycle WIDTH+1. A start during DONE is accepted directly.
//  sum is a shift register and is only meaningful when done is seen; it is
//  held afterwards until the next accepted start.
// ---------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SERIAL_WIDTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t           state;
   logic [WIDTH-1:0] sh_a, sh_b;
   logic [WIDTH-1:0] sum_q;
   logic             carry;
   logic [CNT_W-1:0] count;
   logic             busy_q, done_q, cout_q;

   logic             fa_sum, fa_cout;
   logic [WIDTH-1:0] sum_shift;

   full_adder u_fa (
      .a    (sh_a[0]),
      .b    (sh_b[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New result bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
   generate
      if (WIDTH == 1) begin : g_w1
         assign sum_shift = fa_sum;
      end else begin : g_wn
         assign sum_shift = {fa_sum, sum_q[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         sh_a   <= '0;
         sh_b   <= '0;
         sum_q  <= '0;
         carry  <= 1'b0;
         count  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  sh_a   <= bus.a;
                  sh_b   <= bus.b;
                  carry  <= 1'b0;
                  count  <= '0;
                  busy_q <= 1'b1;
                  state  <= ST_RUN;
               end else begin
                  state  <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sum_q <= sum_shift;
               carry <= fa_cout;
               sh_a  <= sh_a >> 1;
               sh_b  <= sh_b >> 1;
               count <= count + 1'b1;
               if (count == CNT_W'(WIDTH - 1)) begin
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  cout_q <= fa_cout;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.sum       = sum_q;
   assign bus.carry_out = cout_q;

endmodule
